// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-128 decryption round controller.
// Step masks are ordered {KE, ISR, ISB, AR, IMC}.
package aes_dec_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StKeyExp,
    StRound,
    StDone
  } state_t;

  localparam logic [4:0] MaskNone   = 5'b00000;
  localparam logic [4:0] MaskKeyExp = 5'b10000;
  localparam logic [4:0] MaskFirst  = 5'b00010;
  localparam logic [4:0] MaskMid    = 5'b01111;
  localparam logic [4:0] MaskLast   = 5'b01110;

  // Rounds finished so far: rnd=10 -> none, rnd=0 -> all but the final one.
  function automatic logic [9:0] round_therm(input logic [3:0] rnd);
    return 10'h3FF >> rnd;
  endfunction

endpackage

// File: rtl/aes_dec_enb_dec.sv
// Step-enable decode from registered FSM state and round number.
module aes_dec_enb_dec
  import aes_dec_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] rnd_no_i,
  output logic       enb_ke_o,
  output logic       enb_isr_o,
  output logic       enb_isb_o,
  output logic       enb_ar_o,
  output logic       enb_imc_o
);

  logic [4:0] mask;

  always_comb begin
    mask = MaskNone;
    unique case (state_i)
      StKeyExp: mask = MaskKeyExp;
      StRound: begin
        if (rnd_no_i == NR) begin
          mask = MaskFirst;
        end else if (rnd_no_i == 4'd0) begin
          mask = MaskLast;
        end else begin
          mask = MaskMid;
        end
      end
      default: mask = MaskNone;
    endcase
  end

  assign {enb_ke_o, enb_isr_o, enb_isb_o, enb_ar_o, enb_imc_o} = mask;

endmodule

// File: rtl/aes_dec_cntx.sv
// AES-128 decryption controller: key expansion, 11 round steps, done pulse.
// Optional AES_DEC_KEYCACHE_EN skips key expansion when the cached key is still valid.
module aes_dec_cntx
  import aes_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       keyNew,
  output logic       accept,
  output logic [3:0] rndNo,
  output logic [3:0] keyIdx,
  output logic       enbKE,
  output logic       enbISR,
  output logic       enbISB,
  output logic       enbAR,
  output logic       enbIMC,
  output logic       busy,
  output logic       done,
  output logic [9:0] completed_round
);

  state_t     state_q;
  logic [3:0] rnd_no_q;
  logic [3:0] key_idx_q;
  logic       done_q;
  logic       cache_hit;

`ifdef AES_DEC_KEYCACHE_EN
  logic key_valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_valid_q <= 1'b0;
    end else if (state_q == StKeyExp && key_idx_q == NR) begin
      key_valid_q <= 1'b1;
    end
  end

  assign cache_hit = !keyNew && key_valid_q;
`else
  logic unused_keynew;
  assign unused_keynew = keyNew;
  assign cache_hit     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      rnd_no_q  <= 4'd0;
      key_idx_q <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cache_hit) begin
              state_q   <= StRound;
              rnd_no_q  <= NR;
              key_idx_q <= NR;
            end else begin
              state_q   <= StKeyExp;
              key_idx_q <= 4'd1;
            end
          end
        end
        StKeyExp: begin
          if (key_idx_q == NR) begin
            state_q   <= StRound;
            rnd_no_q  <= NR;
            key_idx_q <= NR;
          end else begin
            key_idx_q <= key_idx_q + 4'd1;
          end
        end
        StRound: begin
          if (rnd_no_q == 4'd0) begin
            state_q   <= StDone;
            key_idx_q <= 4'd0;
            done_q    <= 1'b1;
          end else begin
            // Round key index tracks the round being decrypted.
            rnd_no_q  <= rnd_no_q - 4'd1;
            key_idx_q <= rnd_no_q - 4'd1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          rnd_no_q  <= 4'd0;
          key_idx_q <= 4'd0;
        end
        default: begin
          state_q   <= StIdle;
          rnd_no_q  <= 4'd0;
          key_idx_q <= 4'd0;
        end
      endcase
    end
  end

  aes_dec_enb_dec u_enb_dec (
    .state_i   (state_q),
    .rnd_no_i  (rnd_no_q),
    .enb_ke_o  (enbKE),
    .enb_isr_o (enbISR),
    .enb_isb_o (enbISB),
    .enb_ar_o  (enbAR),
    .enb_imc_o (enbIMC)
  );

  always_comb begin
    completed_round = 10'h000;
    unique case (state_q)
      StRound: completed_round = round_therm(rnd_no_q);
      StDone:  completed_round = 10'h3FF;
      default: completed_round = 10'h000;
    endcase
  end

  assign accept = (state_q == StIdle);
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign rndNo  = rnd_no_q;
  assign keyIdx = key_idx_q;

endmodule

// File: tb/tb_aes_dec_cntx.sv
// Scoreboard bench for aes_dec_cntx: per-cycle expected outputs are queued at start
// and compared on the falling edge. Honours AES_DEC_KEYCACHE_EN.
module tb_aes_dec_cntx;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       keyNew;
  logic       accept;
  logic [3:0] rndNo;
  logic [3:0] keyIdx;
  logic       enbKE, enbISR, enbISB, enbAR, enbIMC;
  logic       busy;
  logic       done;
  logic [9:0] completed_round;

  typedef struct packed {
    logic       accept;
    logic       busy;
    logic       done;
    logic       ke;
    logic       isr;
    logic       isb;
    logic       ar;
    logic       imc;
    logic [3:0] rnd;
    logic [3:0] key;
    logic [9:0] comp;
  } obs_t;

  typedef struct {
    obs_t o;
    int   k;
  } sb_t;

`ifdef AES_DEC_KEYCACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  obs_t obs;
  obs_t idle_o;
  sb_t  exp_q[$];
  sb_t  sb_cur;
  int   n_checks;
  int   n_errors;

  assign obs = '{accept: accept, busy: busy, done: done, ke: enbKE, isr: enbISR,
                 isb: enbISB, ar: enbAR, imc: enbIMC, rnd: rndNo, key: keyIdx,
                 comp: completed_round};

  aes_dec_cntx dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .keyNew          (keyNew),
    .accept          (accept),
    .rndNo           (rndNo),
    .keyIdx          (keyIdx),
    .enbKE           (enbKE),
    .enbISR          (enbISR),
    .enbISB          (enbISB),
    .enbAR           (enbAR),
    .enbIMC          (enbIMC),
    .busy            (busy),
    .done            (done),
    .completed_round (completed_round)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs k cycles after the start edge.
  function automatic obs_t model(input int k, input bit cached);
    obs_t o;
    int   r;
    int   c;
    o = '0;
    o.busy = 1'b1;
    if (!cached && k <= 10) begin
      o.ke  = 1'b1;
      o.key = 4'(k);
    end else if (k - (cached ? 0 : 10) <= 11) begin
      r = 11 - (k - (cached ? 0 : 10));
      c = (1 << (10 - r)) - 1;
      o.rnd  = 4'(r);
      o.key  = 4'(r);
      o.ar   = 1'b1;
      o.isr  = (r < 10);
      o.isb  = (r < 10);
      o.imc  = (r < 10) && (r > 0);
      o.comp = c[9:0];
    end else begin
      o.done = 1'b1;
      o.comp = 10'h3FF;
    end
    return o;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        sb_cur = exp_q.pop_front();
        n_checks++;
        if (obs !== sb_cur.o) begin
          n_errors++;
          $display("FAIL trace k=%0d: got %h, expected %h", sb_cur.k, obs, sb_cur.o);
        end
      end
    end
  endtask

  task automatic push_run(input bit cached, input int upto);
    int n;
    n = cached ? 12 : 22;
    if (upto > 0 && upto < n) n = upto;
    for (int k = 1; k <= n; k++) exp_q.push_back('{o: model(k, cached), k: k});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s drain: %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_run(input string name, input bit key_new, input bit cached);
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== idle_o) begin
      n_errors++;
      $display("FAIL %s idle before start: got %h, expected %h", name, obs, idle_o);
    end
    keyNew = key_new;
    start  = 1'b1;
    push_run(cached, 0);
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_drain(name);
  endtask

  task automatic test_reset();
    rstn   = 1'b0;
    start  = 1'b0;
    keyNew = 1'b1;
    #1;
    n_checks++;
    if (obs !== idle_o) begin
      n_errors++;
      $display("FAIL reset state: got %h, expected %h", obs, idle_o);
    end
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== idle_o) begin
      n_errors++;
      $display("FAIL post-reset idle: got %h, expected %h", obs, idle_o);
    end
  endtask

  task automatic test_single_run();
    do_run("single", 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    #1;
    keyNew = 1'b1;
    start  = 1'b1;
    push_run(1'b0, 0);
    wait_drain("b2b_run1");
    // Start stays high: one idle cycle, then the next run begins.
    exp_q.push_back('{o: idle_o, k: 0});
    push_run(1'b0, 0);
    wait_drain("b2b_run2");
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (obs !== idle_o) begin
        n_errors++;
        $display("FAIL b2b no queued start: got %h, expected %h", obs, idle_o);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    #1;
    keyNew = 1'b1;
    start  = 1'b1;
    push_run(1'b0, 15);
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_drain("midrst_prefix");
    n_checks++;
    if (rndNo !== 4'd6) begin
      n_errors++;
      $display("FAIL midrst round before reset: got %0d, expected 6", rndNo);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (obs !== idle_o) begin
      n_errors++;
      $display("FAIL midrst async clear: got %h, expected %h", obs, idle_o);
    end
    @(negedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== idle_o) begin
      n_errors++;
      $display("FAIL midrst idle after release: got %h, expected %h", obs, idle_o);
    end
    // Key-valid flag was cleared, so even keyNew=0 runs the full key expansion.
    do_run("midrst_fresh", 1'b0, 1'b0);
  endtask

  task automatic test_keycache();
    do_run("kc_new1", 1'b1, 1'b0);
    do_run("kc_reuse", 1'b0, CacheEn);
    do_run("kc_new2", 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_o   = '0;
    idle_o.accept = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_single_run();
    test_back_to_back();
    test_mid_reset();
    test_keycache();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
